pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register, replacing the latch-style inter-stage registers (ID/EX, EX/MEM, MEM/WB) with one edge-triggered block.
- Carries a control bundle and a data bundle between pipeline stages using a valid/ready handshake.
- Adds synchronous flush (bubble insertion) and an optional skid entry, so that a registered in_ready does not lose data.
- One instance sits between each pair of stages. Stage-specific bundles are packed into ctrl/data by the instantiating stage.

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/pipe_entry_reg.sv | 41 ++++
 rtl/pipe_stage_reg.sv | 133 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: occupancy state encoding, per-stage bundle widths
// and field offsets used when packing/unpacking the ctrl/data bundles.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam int IDEX_CTRL_W  = 8;
    localparam int IDEX_DATA_W  = 101;
    localparam int EXMEM_CTRL_W = 3;
    localparam int EXMEM_DATA_W = 69;
    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_DATA_W = 69;

    // EX/MEM control bits
    localparam int EXMEM_REGWRITE_BIT = 2;
    localparam int EXMEM_MEMTOREG_BIT = 1;
    localparam int EXMEM_MEMWRITE_BIT = 0;

    // EX/MEM data fields: {alu_result[31:0], write_reg[4:0], store_data[31:0]}
    localparam int EXMEM_STORE_LSB = 0;
    localparam int EXMEM_WREG_LSB  = 32;
    localparam int EXMEM_ALU_LSB   = 37;

    function automatic logic [EXMEM_DATA_W-1:0] exmem_pack_data(
        input logic [31:0] alu_result,
        input logic [4:0]  write_reg,
        input logic [31:0] store_data
    );
        return {alu_result, write_reg, store_data};
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One stage entry: ctrl+data register with load enable and a ctrl-only clear,
// so a killed entry can never carry live control bits forward.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter int DATA_W = EXMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_ctrl_clr,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= '0;
            r_data <= '0;
        end else begin
            if (i_ctrl_clr) begin
                r_ctrl <= '0;
            end else if (i_load) begin
                r_ctrl <= i_ctrl;
            end
            if (i_load) begin
                r_data <= i_data;
            end
        end
    end

    assign o_ctrl = r_ctrl;
    assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Edge-triggered pipeline stage register with valid/ready handshake, flush,
// and an optional skid entry that lets in_ready be a registered signal.
//
// state    | meaning
// ST_EMPTY | no entry held, out_valid=0
// ST_ONE   | main entry valid
// ST_FULL  | main and skid valid, in_ready=0 (SKID=1 only)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter int DATA_W = EXMEM_DATA_W,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    pipe_state_e       r_state;
    logic              r_in_ready;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_load;
    logic              w_skid_load;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_main_ctrl_d;
    logic [DATA_W-1:0] w_main_data_d;

    assign out_valid  = (r_state != ST_EMPTY);
    assign in_ready   = SKID ? r_in_ready : (!out_valid || out_ready);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign occupancy  = r_state;
    assign out_ctrl   = out_valid ? w_main_ctrl : '0;
    assign out_data   = w_main_data;

    // Flush suppresses every load, which is what discards a same-cycle in_fire.
    always_comb begin
        w_main_load = 1'b0;
        w_skid_load = 1'b0;
        if (!flush) begin
            case (r_state)
                ST_EMPTY: w_main_load = w_in_fire;
                ST_ONE: begin
                    w_main_load = w_in_fire & w_out_fire;
                    w_skid_load = SKID & w_in_fire & ~w_out_fire;
                end
                ST_FULL:  w_main_load = w_out_fire;
                default:  w_main_load = 1'b0;
            endcase
        end
    end

    assign w_main_ctrl_d = (r_state == ST_FULL) ? w_skid_ctrl : in_ctrl;
    assign w_main_data_d = (r_state == ST_FULL) ? w_skid_data : in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) r_state <= ST_ONE;
                end
                ST_ONE: begin
                    if (w_skid_load) begin
                        r_state    <= ST_FULL;
                        r_in_ready <= 1'b0;
                    end else if (!w_in_fire && w_out_fire) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_main_load),
        .i_ctrl_clr (flush),
        .i_ctrl     (w_main_ctrl_d),
        .i_data     (w_main_data_d),
        .o_ctrl     (w_main_ctrl),
        .o_data     (w_main_data)
    );

    generate
        if (SKID) begin : g_skid
            pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_load     (w_skid_load),
                .i_ctrl_clr (flush),
                .i_ctrl     (in_ctrl),
                .i_data     (in_data),
                .o_ctrl     (w_skid_ctrl),
                .o_data     (w_skid_data)
            );
        end else begin : g_no_skid
            assign w_skid_ctrl = '0;
            assign w_skid_data = '0;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance share stimulus and are
// checked every cycle against bounded-FIFO models, plus directed literal checks.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_ctrl = '0;
    logic [68:0] in_data = '0;
    logic        out_ready = 1'b1;

    logic        in_ready1, out_valid1, in_ready0, out_valid0;
    logic [2:0]  out_ctrl1, out_ctrl0;
    logic [68:0] out_data1, out_data0;
    logic [1:0]  occ1, occ0;

    int total = 0;
    int bad = 0;

    // model entries are {ctrl, data}
    logic [71:0] q1[$];
    logic [71:0] q0[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(3), .DATA_W(69), .SKID(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
        .out_data(out_data1), .occupancy(occ1)
    );

    pipe_stage_reg #(.CTRL_W(3), .DATA_W(69), .SKID(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
        .out_data(out_data0), .occupancy(occ0)
    );

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // FIFO model: capacity 2 with in_ready = not full (SKID=1);
    // capacity 1 with in_ready = empty or being drained (SKID=0).
    always @(posedge clk or negedge rst_n) begin
        bit ir1, ir0, of1, of0;
        if (!rst_n) begin
            q1.delete();
            q0.delete();
        end else begin
            ir1 = (q1.size() < 2);
            ir0 = (q0.size() == 0) || out_ready;
            of1 = (q1.size() > 0) && out_ready;
            of0 = (q0.size() > 0) && out_ready;
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (of1) void'(q1.pop_front());
                if (in_valid && ir1) q1.push_back({in_ctrl, in_data});
                if (of0) void'(q0.pop_front());
                if (in_valid && ir0) q0.push_back({in_ctrl, in_data});
            end
        end
    end

    always @(negedge clk) begin
        chk("valid1", out_valid1, q1.size() != 0);
        chk("occ1", occ1, q1.size());
        chk("ready1", in_ready1, q1.size() < 2);
        if (q1.size() != 0) begin
            chk("ctrl1", out_ctrl1, q1[0][71:69]);
            chk("data1", out_data1, q1[0][68:0]);
        end else begin
            chk("ctrl1_bubble", out_ctrl1, 3'b000);
        end
        chk("valid0", out_valid0, q0.size() != 0);
        chk("occ0", occ0, q0.size());
        chk("ready0", in_ready0, (q0.size() == 0) || out_ready);
        if (q0.size() != 0) begin
            chk("ctrl0", out_ctrl0, q0[0][71:69]);
            chk("data0", out_data0, q0[0][68:0]);
        end else begin
            chk("ctrl0_bubble", out_ctrl0, 3'b000);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset with upstream active
        in_valid = 1'b1; in_ctrl = 3'b111; in_data = 69'h5; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", out_valid1, 1'b0);
        chk("rst_ctrl", out_ctrl1, 3'b000);
        chk("rst_occ", occ1, 2'd0);
        chk("rst_ready", in_ready1, 1'b1);
        chk("rst_data", out_data1, 69'h0);
        rst_n = 1'b1;
        tick();
        chk("lat_valid", out_valid1, 1'b1);
        chk("lat_data", out_data1, 69'h5);
        chk("lat_ctrl", out_ctrl1, 3'b111);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", out_valid1, 1'b0);

        // 2: streaming
        in_ctrl = 3'b001;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 69'(i);
            tick();
            chk("stream_data", out_data1, 69'(i));
            chk("stream_occ", occ1, 2'd1);
            chk("stream_ready", in_ready1, 1'b1);
        end
        in_valid = 1'b0;
        tick();

        // 3: backpressure into skid
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 69'h11; tick();
        chk("bp_occA", occ1, 2'd1);
        in_data = 69'h22; tick();
        chk("bp_occB", occ1, 2'd2);
        chk("bp_ready", in_ready1, 1'b0);
        chk("bp_headA", out_data1, 69'h11);
        in_valid = 1'b0; out_ready = 1'b1; tick();
        chk("bp_headB", out_data1, 69'h22);
        chk("bp_occ1", occ1, 2'd1);
        tick();
        chk("bp_empty", occ1, 2'd0);

        // 4: flush from FULL, then from ONE with a live in_fire
        out_ready = 1'b0; in_ctrl = 3'b101;
        in_valid = 1'b1; in_data = 69'hA; tick();
        in_data = 69'hB; tick();
        chk("fl_full", occ1, 2'd2);
        flush = 1'b1; in_data = 69'h33; tick();
        chk("fl_valid", out_valid1, 1'b0);
        chk("fl_ctrl", out_ctrl1, 3'b000);
        chk("fl_occ", occ1, 2'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("fl_noC", out_valid1, 1'b0);
        end
        out_ready = 1'b0; in_valid = 1'b1; in_data = 69'hC1; tick();
        chk("fl1_occ", occ1, 2'd1);
        flush = 1'b1; in_data = 69'h33; tick();
        chk("fl1_occ0", occ1, 2'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
        chk("fl1_noC", out_valid1, 1'b0);
        flush = 1'b1; tick();
        flush = 1'b0;
        chk("fl_empty_occ", occ1, 2'd0);

        // 5: SKID=0 combinational in_ready and same-edge replacement
        out_ready = 1'b0; in_ctrl = 3'b010;
        in_valid = 1'b1; in_data = 69'h44; tick();
        chk("s0_held", out_data0, 69'h44);
        in_data = 69'h55; #1;
        chk("s0_rdy_lo", in_ready0, 1'b0);
        out_ready = 1'b1; #1;
        chk("s0_rdy_hi", in_ready0, 1'b1);
        tick();
        chk("s0_repl", out_data0, 69'h55);
        chk("s0_occ", occ0, 2'd1);
        in_valid = 1'b0; tick();
        chk("s0_empty", occ0, 2'd0);

        // 6: async reset while FULL
        out_ready = 1'b0; in_ctrl = 3'b111;
        in_valid = 1'b1; in_data = 69'h66; tick();
        in_data = 69'h77; tick();
        chk("ar_full", occ1, 2'd2);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid1, 1'b0);
        chk("ar_occ", occ1, 2'd0);
        chk("ar_ctrl", out_ctrl1, 3'b000);
        chk("ar_data", out_data1, 69'h0);
        chk("ar_ready", in_ready1, 1'b1);
        chk("ar_valid0", out_valid0, 1'b0);
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("ar_gone", out_valid1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
